// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: multicycle FSM states, opcodes and mux select codes.
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/mccontrol_branchres.sv
// Branch condition resolution from the ALU decoder's one-hot branch type and ALU flags.
module branchres (
    input  logic [3:0] Branch,
    input  logic       Zero,
    input  logic       Lt,
    output logic       taken
);

    // Non-one-hot or unknown branch types fall to the default: not taken.
    always_comb begin
        taken = 1'b0;
        case (Branch)
            4'b0001: taken = Zero;
            4'b0010: taken = Lt;
            4'b0100: taken = ~Zero;
            4'b1000: taken = ~Lt;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mccontrol.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
module mccontrol
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [3:0] Branch,
    input  logic       Zero,
    input  logic       Lt,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IllegalOp,
    output logic [3:0] State
);

    statetype state, nextstate, effstate;
    logic     pcupdate, branchst, taken;
    logic     irwrite_d, regwrite_d, memwrite_d, illegal_d;

    branchres u_branchres (
        .Branch (Branch),
        .Zero   (Zero),
        .Lt     (Lt),
        .taken  (taken)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= nextstate;
    end

    always_comb begin
        nextstate = FETCH;
        case (state)
            FETCH:    nextstate = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nextstate = MEMADR;
                    OP_R:         nextstate = EXECR;
                    OP_I:         nextstate = EXECI;
                    OP_B:         nextstate = BRANCH;
                    OP_JAL:       nextstate = JAL;
                    default:      nextstate = FETCH;
                endcase
            end
            MEMADR:   nextstate = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  nextstate = MEMWB;
            MEMWB:    nextstate = FETCH;
            MEMWRITE: nextstate = FETCH;
            EXECR:    nextstate = ALUWB;
            EXECI:    nextstate = ALUWB;
            JAL:      nextstate = ALUWB;
            ALUWB:    nextstate = FETCH;
            BRANCH:   nextstate = FETCH;
            default:  nextstate = FETCH;
        endcase
    end

    // During reset the decode sees FETCH so muxes park there; write enables are gated below.
    assign effstate = reset ? FETCH : state;

    always_comb begin
        ALUOp      = ALUOP_ADD;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ResultSrc  = RES_ALUOUT;
        AdrSrc     = 1'b0;
        irwrite_d  = 1'b0;
        regwrite_d = 1'b0;
        memwrite_d = 1'b0;
        illegal_d  = 1'b0;
        pcupdate   = 1'b0;
        branchst   = 1'b0;
        case (effstate)
            FETCH: begin
                irwrite_d = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                pcupdate  = 1'b1;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL: illegal_d = 1'b0;
                    default:                                illegal_d = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc  = RES_DATA;
                regwrite_d = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                memwrite_d = 1'b1;
            end
            EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FN;
            end
            EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FN;
            end
            ALUWB:    regwrite_d = 1'b1;
            JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pcupdate = 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = SRCA_RS1;
                ALUOp    = ALUOP_BR;
                branchst = 1'b1;
                illegal_d = (Branch == 4'b0000);
            end
            default: ;
        endcase
    end

    assign IRWrite   = irwrite_d  & ~reset;
    assign RegWrite  = regwrite_d & ~reset;
    assign MemWrite  = memwrite_d & ~reset;
    assign IllegalOp = illegal_d  & ~reset;
    assign PCWrite   = (pcupdate | (branchst & taken)) & ~reset;
    assign State     = effstate;

endmodule

// File: tb/tb_mccontrol.sv
// Directed testbench for mccontrol: state sequences, control outputs, branch resolution and reset.
module tb_mccontrol;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [3:0] Branch;
    logic       Zero, Lt;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp;
    logic [3:0] State;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mccontrol dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .Branch    (Branch),
        .Zero      (Zero),
        .Lt        (Lt),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .IllegalOp (IllegalOp),
        .State     (State)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_branch(input logic [3:0] br, input logic z, input logic lt,
                              input logic exp_pcw, input logic exp_ill, input string tag);
        op = 7'b1100011; Branch = br; Zero = z; Lt = lt;
        #1 chk({tag, "_fetch"}, {4'b0, State}, 8'd0);
        cyc(); chk({tag, "_dec"}, {4'b0, State}, 8'd1);
        chk({tag, "_dec_pcw"}, {7'b0, PCWrite}, 8'd0);
        cyc(); chk({tag, "_state"}, {4'b0, State}, 8'd9);
        chk({tag, "_aluop"}, {6'b0, ALUOp}, 8'd1);
        chk({tag, "_pcw"}, {7'b0, PCWrite}, {7'b0, exp_pcw});
        chk({tag, "_ill"}, {7'b0, IllegalOp}, {7'b0, exp_ill});
        cyc(); chk({tag, "_back"}, {4'b0, State}, 8'd0);
    endtask

    initial begin
        reset = 1'b1; op = 7'b0; Branch = 4'b0; Zero = 1'b0; Lt = 1'b0;
        cyc(); cyc();
        chk("rst_state", {4'b0, State}, 8'd0);
        chk("rst_irwrite", {7'b0, IRWrite}, 8'd0);
        chk("rst_pcwrite", {7'b0, PCWrite}, 8'd0);
        chk("rst_srcb", {6'b0, ALUSrcB}, 8'd2);
        chk("rst_ressrc", {6'b0, ResultSrc}, 8'd2);

        reset = 1'b0; op = 7'b0000011;
        #1 chk("lw_s0", {4'b0, State}, 8'd0);
        chk("lw_s0_ir", {7'b0, IRWrite}, 8'd1);
        chk("lw_s0_pcw", {7'b0, PCWrite}, 8'd1);
        cyc(); chk("lw_s1", {4'b0, State}, 8'd1);
        chk("lw_s1_srca", {6'b0, ALUSrcA}, 8'd1);
        chk("lw_s1_rw", {7'b0, RegWrite}, 8'd0);
        cyc(); chk("lw_s2", {4'b0, State}, 8'd2);
        chk("lw_s2_srca", {6'b0, ALUSrcA}, 8'd2);
        chk("lw_s2_srcb", {6'b0, ALUSrcB}, 8'd1);
        cyc(); chk("lw_s3", {4'b0, State}, 8'd3);
        chk("lw_s3_adr", {7'b0, AdrSrc}, 8'd1);
        chk("lw_s3_rw", {7'b0, RegWrite}, 8'd0);
        cyc(); chk("lw_s4", {4'b0, State}, 8'd4);
        chk("lw_s4_rw", {7'b0, RegWrite}, 8'd1);
        chk("lw_s4_res", {6'b0, ResultSrc}, 8'd1);
        cyc(); chk("lw_end", {4'b0, State}, 8'd0);
        chk("lw_end_rw", {7'b0, RegWrite}, 8'd0);

        op = 7'b0100011;
        cyc(); chk("sw_s1", {4'b0, State}, 8'd1);
        cyc(); chk("sw_s2", {4'b0, State}, 8'd2);
        chk("sw_s2_mw", {7'b0, MemWrite}, 8'd0);
        cyc(); chk("sw_s5", {4'b0, State}, 8'd5);
        chk("sw_s5_mw", {7'b0, MemWrite}, 8'd1);
        chk("sw_s5_adr", {7'b0, AdrSrc}, 8'd1);
        cyc(); chk("sw_end", {4'b0, State}, 8'd0);
        chk("sw_end_mw", {7'b0, MemWrite}, 8'd0);
        chk("sw_end_adr", {7'b0, AdrSrc}, 8'd0);

        run_branch(4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, "beq_t");
        run_branch(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, "bne_nt");
        run_branch(4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, "bge_t");
        run_branch(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, "blt_t");
        run_branch(4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, "br_multi");
        run_branch(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, "br_none");

        op = 7'b0110011;
        cyc(); chk("r_s1", {4'b0, State}, 8'd1);
        cyc(); chk("r_s6", {4'b0, State}, 8'd6);
        chk("r_s6_aluop", {6'b0, ALUOp}, 8'd2);
        chk("r_s6_srcb", {6'b0, ALUSrcB}, 8'd0);
        cyc(); chk("r_s8", {4'b0, State}, 8'd8);
        chk("r_s8_rw", {7'b0, RegWrite}, 8'd1);
        op = 7'b1101111;
        cyc(); chk("r_end", {4'b0, State}, 8'd0);
        cyc(); chk("jal_s1", {4'b0, State}, 8'd1);
        cyc(); chk("jal_s10", {4'b0, State}, 8'd10);
        chk("jal_pcw", {7'b0, PCWrite}, 8'd1);
        chk("jal_srca", {6'b0, ALUSrcA}, 8'd1);
        chk("jal_srcb", {6'b0, ALUSrcB}, 8'd2);
        chk("jal_rw", {7'b0, RegWrite}, 8'd0);
        cyc(); chk("jal_s8", {4'b0, State}, 8'd8);
        chk("jal_s8_rw", {7'b0, RegWrite}, 8'd1);
        op = 7'b0010011;
        cyc(); chk("jal_end", {4'b0, State}, 8'd0);
        cyc(); chk("i_s1", {4'b0, State}, 8'd1);
        cyc(); chk("i_s7", {4'b0, State}, 8'd7);
        chk("i_s7_srcb", {6'b0, ALUSrcB}, 8'd1);
        chk("i_s7_aluop", {6'b0, ALUOp}, 8'd2);
        cyc(); chk("i_s8", {4'b0, State}, 8'd8);
        op = 7'b1111111;
        cyc(); chk("i_end", {4'b0, State}, 8'd0);
        chk("ill_s0_ill", {7'b0, IllegalOp}, 8'd0);
        cyc(); chk("ill_s1", {4'b0, State}, 8'd1);
        chk("ill_s1_ill", {7'b0, IllegalOp}, 8'd1);
        chk("ill_s1_rw", {7'b0, RegWrite}, 8'd0);
        chk("ill_s1_mw", {7'b0, MemWrite}, 8'd0);
        cyc(); chk("ill_end", {4'b0, State}, 8'd0);
        chk("ill_end_ill", {7'b0, IllegalOp}, 8'd0);

        op = 7'b0000011;
        cyc(); cyc(); cyc(); cyc();
        chk("rmid_s4", {4'b0, State}, 8'd4);
        reset = 1'b1;
        #1 chk("rmid_rw0", {7'b0, RegWrite}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rmid_rw", {7'b0, RegWrite}, 8'd0);
            chk("rmid_state", {4'b0, State}, 8'd0);
        end
        reset = 1'b0;
        #1 chk("rel_state", {4'b0, State}, 8'd0);
        chk("rel_ir", {7'b0, IRWrite}, 8'd1);
        chk("rel_pcw", {7'b0, PCWrite}, 8'd1);
        cyc(); chk("rel_s1", {4'b0, State}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mccontrol.md
# mccontrol

Multicycle control unit for the RISC-V core: an 11-state Moore FSM that sequences fetch, decode, execute, memory and writeback, and drives the datapath muxes and write enables. It sits directly upstream of the ALU decoder: it supplies `ALUOp`, takes back the decoder's one-hot `Branch[3:0]`, and resolves the PC write enable from the ALU flags. It replaces the single-cycle main decoder when the core moves to a shared instruction/data memory.

## Interface
Parameters:
- None. Opcodes and state encodings are fixed in the package.

Ports:
- `clk  in  1`  rising-edge clock.
- `reset  in  1`  synchronous, active-high.
- `op  in  7`  `Instr[6:0]` from the instruction register.
- `Branch  in  4`  one-hot from the ALU decoder: bit0 beq, bit1 blt, bit2 bne, bit3 bge.
- `Zero  in  1`  ALU result == 0.
- `Lt  in  1`  signed less-than from the ALU subtract.
- `ALUOp  out  2`  to the ALU decoder.
- `ALUSrcA  out  2`  source A select: 00 PC, 01 OldPC, 10 rs1.
- `ALUSrcB  out  2`  source B select: 00 rs2, 01 imm, 10 constant 4.
- `ResultSrc  out  2`  result select: 00 ALUOut, 01 Data, 10 ALUResult.
- `AdrSrc  out  1`  memory address select: 0 PC, 1 Result.
- `IRWrite  out  1`  instruction register write enable.
- `PCWrite  out  1`  PC write enable.
- `RegWrite  out  1`  register file write enable.
- `MemWrite  out  1`  memory write enable.
- `IllegalOp  out  1`  one-cycle pulse on an unsupported opcode.
- `State  out  4`  current state encoding, for debug.

## Operation
- States, in 4-bit encoding order 0–10: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL. Encodings 11–15 are unreachable; the FSM moves to FETCH on the next edge.
- Outputs are a function of state only; every output not listed for a state is 0.
  - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01 (branch target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
  - BRANCH: ALUSrcA=10, ALUOp=01, BranchSt=1.
- Transitions out of DECODE by `op`:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - Any other value → FETCH, with IllegalOp=1 for that DECODE cycle.
- Other transitions:
  - MEMADR → MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECR, EXECI and JAL → ALUWB → FETCH.
  - BRANCH → FETCH.
- Branch resolution: taken = (Branch[0]&Zero) | (Branch[1]&Lt) | (Branch[2]&~Zero) | (Branch[3]&~Lt).
  - Any bit of `Branch` that is X, or a non-one-hot value, counts as not taken.
  - If `Branch`==0 in BRANCH, then IllegalOp=1.
- PCWrite = PCUpdate | (BranchSt & taken).

## Timing
- Reset: while `reset`=1, state←FETCH on each edge. IRWrite, PCWrite, RegWrite, MemWrite and IllegalOp are forced to 0; the remaining outputs take their FETCH values.
- Reset mid-instruction:
  - The instruction is abandoned and no write enable asserts afterwards.
  - The first cycle after `reset` falls is FETCH.
- Instruction latency in cycles, FETCH inclusive:
  - lw 5.
  - sw 4.
  - R-type, I-type ALU and jal 4.
  - Branch 3.
  - Illegal opcode 2.
- `op` is sampled only in DECODE and MEMADR. The IR is stable in those states because IRWrite=1 only in FETCH.
- `Zero`, `Lt` and `Branch` are used combinationally in BRANCH only; PCWrite settles in that same cycle.
- No stall input: every state lasts exactly one cycle.

## Structure
- Shared package `riscv_pkg`:
  - `statetype` enum with the 4-bit encodings above.
  - Opcode localparams `OP_LW`, `OP_SW`, `OP_R`, `OP_I`, `OP_B`, `OP_JAL`.
  - `ALUOp` localparams `ALUOP_ADD`=00, `ALUOP_BR`=01, `ALUOP_FN`=10.
- Sub-module `branchres` (combinational): inputs Branch, Zero, Lt; output taken. It is reusable in a later pipelined core.
- The top module holds the state register, the next-state logic and the output decode.

## Test plan
- Reset held for 3 cycles mid-MEMWB → RegWrite=0 throughout; State=0 one cycle after release, with IRWrite=1 and PCWrite=1.
- op=0000011 → State sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; ResultSrc=01 there.
- op=0100011 → sequence 0,1,2,5,0; MemWrite=1 and AdrSrc=1 only in state 5.
- op=1100011:
  - Branch=0001, Zero=1 → PCWrite=1 in state 9.
  - Branch=0100, Zero=1 → PCWrite=0.
  - Branch=1000, Lt=0 → PCWrite=1.
- op=0110011 then op=1101111 → ALUOp=10 in EXECR; JAL state has PCWrite=1, ALUSrcA=01 and ALUSrcB=10, followed by ALUWB with RegWrite=1.
- op=1111111 → sequence 0,1,0 with IllegalOp=1 for exactly one cycle; no RegWrite or MemWrite.
